// File: rtl/alu_pkg.sv
// Shared ALU datapath types: operation encodings, sequencer states and a
// small signed-overflow helper used by the multi-cycle adder/subtractor.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_ADC = 2'd1,
      OP_SUB = 2'd2,
      OP_SBB = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Two's-complement overflow: both addends share a sign and the sum's
   // sign differs from it.
   function automatic logic signed_ovr(input logic a_msb,
                                       input logic b_msb,
                                       input logic r_msb);
      signed_ovr = (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in and carry-out; one slice of
// the sequential adder/subtractor.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] total_s;

   // Widen by one bit so the top bit of the sum is the chunk carry.
   always_comb begin
      total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   end

   assign sum  = total_s[CHUNK-1:0];
   assign cout = total_s[CHUNK];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: processes WIDTH bits CHUNK at a time,
// chaining the carry between chunks, with valid/ready on both sides and
// carry/overflow/zero/negative flags registered with the final chunk.
module seq_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             ovr,
   output logic             zero,
   output logic             neg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
         $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   state_t            state_r;
   logic [KW-1:0]     k_r;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic              carry_r;
   logic [WIDTH-1:0]  result_r;
   logic              c_out_r;
   logic              ovr_r;
   logic              zero_r;
   logic              neg_r;
   logic              in_ready_r;
   logic              out_valid_r;

   logic [WIDTH-1:0]  b_eff_s;
   logic              carry_init_s;
   logic [CHUNK-1:0]  a_chunk_s;
   logic [CHUNK-1:0]  b_chunk_s;
   logic [CHUNK-1:0]  sum_s;
   logic              cout_s;
   logic [WIDTH-1:0]  res_next_s;

   // Decode op into the effective B operand and the initial carry.
   always_comb begin
      b_eff_s      = b;
      carry_init_s = 1'b0;
      case (op_t'(op))
         OP_ADD: begin
            b_eff_s      = b;
            carry_init_s = 1'b0;
         end
         OP_ADC: begin
            b_eff_s      = b;
            carry_init_s = c_in;
         end
         OP_SUB: begin
            b_eff_s      = ~b;
            carry_init_s = 1'b1;
         end
         OP_SBB: begin
            b_eff_s      = ~b;
            carry_init_s = c_in;
         end
         default: begin
            b_eff_s      = b;
            carry_init_s = 1'b0;
         end
      endcase
   end

   // Select chunk k of the latched operands for the shared chunk adder.
   always_comb begin
      a_chunk_s = {CHUNK{1'b0}};
      b_chunk_s = {CHUNK{1'b0}};
      for (int i = 0; i < NCHUNK; i++) begin
         a_chunk_s = a_chunk_s |
                     ((k_r == KW'(i)) ? a_r[i*CHUNK +: CHUNK] : {CHUNK{1'b0}});
         b_chunk_s = b_chunk_s |
                     ((k_r == KW'(i)) ? b_r[i*CHUNK +: CHUNK] : {CHUNK{1'b0}});
      end
   end

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a    (a_chunk_s),
      .b    (b_chunk_s),
      .cin  (carry_r),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // Result as it will look after this cycle's chunk is written; the flags
   // on the last chunk are taken from this so they see the final MSB.
   always_comb begin
      res_next_s = result_r;
      for (int i = 0; i < NCHUNK; i++) begin
         res_next_s[i*CHUNK +: CHUNK] = (k_r == KW'(i)) ? sum_s
                                                       : result_r[i*CHUNK +: CHUNK];
      end
   end

   // Sequencer: accept in IDLE, one chunk per BUSY cycle, hold in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         k_r         <= {KW{1'b0}};
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         c_out_r     <= 1'b0;
         ovr_r       <= 1'b0;
         zero_r      <= 1'b0;
         neg_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid) begin
                  a_r        <= a;
                  b_r        <= b_eff_s;
                  carry_r    <= carry_init_s;
                  k_r        <= {KW{1'b0}};
                  state_r    <= S_BUSY;
                  in_ready_r <= 1'b0;
               end else begin
                  state_r    <= S_IDLE;
               end
            end
            S_BUSY: begin
               result_r <= res_next_s;
               carry_r  <= cout_s;
               if (k_r == K_LAST) begin
                  state_r     <= S_DONE;
                  out_valid_r <= 1'b1;
                  c_out_r     <= cout_s;
                  ovr_r       <= signed_ovr(a_r[WIDTH-1], b_r[WIDTH-1],
                                            res_next_s[WIDTH-1]);
                  zero_r      <= (res_next_s == {WIDTH{1'b0}});
                  neg_r       <= res_next_s[WIDTH-1];
               end else begin
                  k_r <= k_r + KW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_r     <= S_IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end else begin
                  state_r     <= S_DONE;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               k_r         <= {KW{1'b0}};
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign c_out     = c_out_r;
   assign ovr       = ovr_r;
   assign zero      = zero_r;
   assign neg       = neg_r;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed self-checking bench for seq_addsub (WIDTH=16, CHUNK=8).
module tb_seq_addsub;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        c_out;
   logic        ovr;
   logic        zero;
   logic        neg;

   int tests_run;
   int tests_failed;

   seq_addsub #(.WIDTH(16), .CHUNK(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .c_out     (c_out),
      .ovr       (ovr),
      .zero      (zero),
      .neg       (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operation, wait for its acceptance edge, then count edges
   // until out_valid (bounded). Outputs sampled 1 time unit after the edge.
   task automatic do_op(input logic [1:0] o, input logic [15:0] va,
                        input logic [15:0] vb, input logic ci,
                        output logic acc, output int lat);
      @(negedge clk);
      op = o; a = va; b = vb; c_in = ci; in_valid = 1'b1;
      acc = in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; op = 2'd3; c_in = 1'b1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
         end
      end
   endtask

   // Complete the output handshake.
   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      tests_run++;
      if ({result, c_out, ovr, zero, neg} !== 20'h00000) begin
         tests_failed++;
         $display("FAIL reset_out: result=%h flags=%b%b%b%b, want 0000 0000",
                  result, c_out, ovr, zero, neg);
      end
   endtask

   task automatic test_add();
      logic acc; int lat;
      do_op(2'd0, 16'h00FF, 16'h0001, 1'b1, acc, lat);
      tests_run++;
      if (acc !== 1'b1 || lat !== 2) begin
         tests_failed++;
         $display("FAIL add_latency: accepted=%b latency=%0d, want 1 2", acc, lat);
      end
      tests_run++;
      if (result !== 16'h0100 || {c_out, ovr, zero, neg} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL add_carry_chain: result=%h cvzn=%b%b%b%b, want 0100 0000",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL add_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      do_op(2'd0, 16'h7FFF, 16'h0001, 1'b0, acc, lat);
      tests_run++;
      if (result !== 16'h8000 || {c_out, ovr, zero, neg} !== 4'b0101) begin
         tests_failed++;
         $display("FAIL add_ovr_pos: result=%h cvzn=%b%b%b%b, want 8000 0101",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
      do_op(2'd0, 16'h8000, 16'h8000, 1'b0, acc, lat);
      tests_run++;
      if (result !== 16'h0000 || {c_out, ovr, zero, neg} !== 4'b1110) begin
         tests_failed++;
         $display("FAIL add_ovr_neg: result=%h cvzn=%b%b%b%b, want 0000 1110",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
   endtask

   task automatic test_sub();
      logic acc; int lat;
      do_op(2'd2, 16'h0000, 16'h0001, 1'b0, acc, lat);
      tests_run++;
      if (result !== 16'hFFFF || {c_out, ovr, zero, neg} !== 4'b0001) begin
         tests_failed++;
         $display("FAIL sub_borrow: result=%h cvzn=%b%b%b%b, want ffff 0001",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
      do_op(2'd2, 16'h1234, 16'h1234, 1'b0, acc, lat);
      tests_run++;
      if (result !== 16'h0000 || {c_out, ovr, zero, neg} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL sub_equal: result=%h cvzn=%b%b%b%b, want 0000 1010",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
   endtask

   task automatic test_adc_sbb();
      logic acc; int lat;
      do_op(2'd1, 16'hFFFF, 16'h0000, 1'b1, acc, lat);
      tests_run++;
      if (result !== 16'h0000 || {c_out, ovr, zero, neg} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL adc_wrap: result=%h cvzn=%b%b%b%b, want 0000 1010",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
      do_op(2'd3, 16'h8000, 16'h0001, 1'b1, acc, lat);
      tests_run++;
      if (result !== 16'h7FFF || {c_out, ovr, zero, neg} !== 4'b1100) begin
         tests_failed++;
         $display("FAIL sbb_ovr: result=%h cvzn=%b%b%b%b, want 7fff 1100",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
      do_op(2'd3, 16'h0005, 16'h0002, 1'b0, acc, lat);
      tests_run++;
      if (result !== 16'h0002 || {c_out, ovr, zero, neg} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL sbb_borrow_in: result=%h cvzn=%b%b%b%b, want 0002 1000",
                  result, c_out, ovr, zero, neg);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      logic acc; int lat; int bad;
      do_op(2'd0, 16'h1111, 16'h2222, 1'b0, acc, lat);
      @(negedge clk);
      op = 2'd2; a = 16'h0010; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h3333 ||
             {c_out, ovr, zero, neg} !== 4'b0000)
            bad = bad + 1;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL bp_hold: %0d of 5 cycles unstable, want 0 (last result=%h in_ready=%b)",
                  bad, result, in_ready);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
         end
      end
      tests_run++;
      if (lat !== 2 || result !== 16'h000F || {c_out, ovr, zero, neg} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL bp_next_op: latency=%0d result=%h cvzn=%b%b%b%b, want 2 000f 1000",
                  lat, result, c_out, ovr, zero, neg);
      end
   endtask

   task automatic test_reset_mid_busy();
      logic acc; int lat;
      @(negedge clk);
      op = 2'd0; a = 16'h4444; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_busy: out_valid=%b result=%h in_ready=%b, want 0 0000 1",
                  out_valid, result, in_ready);
      end
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(2'd0, 16'h0003, 16'h0004, 1'b0, acc, lat);
      tests_run++;
      if (acc !== 1'b1 || lat !== 2 || result !== 16'h0007 ||
          {c_out, ovr, zero, neg} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_recover: acc=%b latency=%0d result=%h, want 1 2 0007",
                  acc, lat, result);
      end
      release_out();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a = 16'h0000; b = 16'h0000; c_in = 1'b0; op = 2'd0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_add();
      test_sub();
      test_adc_sbb();
      test_backpressure();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised multi-cycle adder/subtractor for the ALU datapath. It processes a WIDTH-bit operation CHUNK bits per cycle, chaining the carry between chunks, and supports add, add-with-carry, subtract and subtract-with-borrow. Operands enter and results leave through valid/ready handshakes, so the block sits between the operand-fetch stage and the ALU result mux. Status flags are carry, overflow, zero and negative.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands and op presented
- in_ready  out  1  block can accept; high iff state is IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in; used by ADC and SBB only
- op  in  2  0 ADD, 1 ADC, 2 SUB, 3 SBB
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  sum/difference
- c_out  out  1  carry out of MSB; for SUB/SBB, 1 = no borrow
- ovr  out  1  signed overflow
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch a, b_eff and carry, clear chunk index k, and go to BUSY.
  - ADD: b_eff=b, carry=0
  - ADC: b_eff=b, carry=c_in
  - SUB: b_eff=~b, carry=1
  - SBB: b_eff=~b, carry=c_in
- BUSY: each cycle, add chunk k of a and b_eff plus carry. Write chunk k of the result register and store the chunk carry-out as the next carry.
  - If k==NCHUNK-1, go to DONE and register the flags.
  - Otherwise increment k.
- Flags, registered on the last BUSY edge:
  - c_out = final carry
  - ovr = (a[W-1]==b_eff[W-1]) && (res[W-1]!=a[W-1]), computed from the final result including the chunk just written
  - zero = (res==0) over the full WIDTH
  - neg = res[W-1]
- DONE: out_valid=1. result and flags hold stable until out_ready. On out_valid && out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Operand and op changes after acceptance have no effect.
- Result register bits may change during BUSY. They are meaningful only while out_valid=1.
- CHUNK==WIDTH is legal: a single BUSY cycle.
- All arithmetic is modulo 2^WIDTH. Chunk sums are CHUNK+1 bits wide, with the top bit used as carry.

## Timing
- Reset (rst_n low, async) forces:
  - state IDLE, k=0
  - result=0, c_out=0, ovr=0, zero=0, neg=0, out_valid=0
  - in_ready=1 while in reset and after it
- Reset mid-BUSY or mid-DONE aborts the operation with no output. out_valid drops immediately.
- Latency: out_valid rises NCHUNK clock edges after the accepting edge (2 for defaults).
- Minimum issue interval: NCHUNK+2 cycles (accept, NCHUNK busy, DONE handshake). in_ready returns one edge after the output handshake.
- No combinational path from in_valid to in_ready, or from out_ready to in_ready/out_valid.

## Structure
- Shared package alu_pkg holds:
  - op_t enum: OP_ADD, OP_ADC, OP_SUB, OP_SBB
  - state enum: S_IDLE, S_BUSY, S_DONE
- One sub-module, chunk_adder: combinational, parameter CHUNK, ports a, b, cin, sum, cout. seq_addsub instantiates it once and muxes chunk k into it.
- Chunk index width is $clog2(NCHUNK), minimum 1.
- Elaboration check: WIDTH % CHUNK == 0 and CHUNK >= 1.

## Test plan
All scenarios use WIDTH=16, CHUNK=8.
- ADD 0x00FF+0x0001, c_in=1 -> result 0x0100, c_out0, ovr0, zero0, neg0; out_valid exactly 2 edges after accept (carry crosses the chunk boundary; c_in ignored).
- ADD 0x7FFF+0x0001 -> 0x8000, ovr1, neg1, c_out0. Then ADD 0x8000+0x8000 -> 0x0000, c_out1, ovr1, zero1.
- SUB 0x0000-0x0001 -> 0xFFFF, c_out0, neg1, ovr0. Then SUB 0x1234-0x1234 -> 0x0000, c_out1, zero1.
- ADC 0xFFFF+0x0000, c_in=1 -> 0x0000, c_out1, zero1, ovr0. Then SBB 0x8000-0x0001, c_in=1 -> 0x7FFF, c_out1, ovr1. Then SBB 0x0005-0x0002, c_in=0 -> 0x0002, c_out1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving a new in_valid.
  - result and flags must stay stable, in_ready=0, and the new request is not accepted.
  - After out_ready, in_ready rises next edge and the new op completes correctly.
- Reset: assert rst_n=0 in the first BUSY cycle.
  - out_valid=0, result=0 and in_ready=1 immediately.
  - After release, ADD 0x0003+0x0004 -> 0x0007 with normal latency.
